dual_port_ram_core: RTL and testbench



---
 rtl/dual_port_ram_core.sv | 90 +++++++++
 tb/tb_dual_port_ram_core.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/dual_port_ram_core.sv
// dual_port_ram_core
// Simple dual-port synchronous RAM: one write port and one independent read port on a
// single clock. Reads have one clock of latency through an internal read register;
// data_out is that register gated combinationally by oe (zero when oe is low).
//
// Ports:
//   clk         rising-edge clock for all state changes except reset
//   rst_n       asynchronous active-low reset; clears every word and the read register
//   cs          chip select; when low both ports are idle
//   we / re     write / read enable (qualified by cs)
//   oe          output enable; forces data_out to zero when low
//   data_in     write data
//   wr_address  write address; writes at or beyond DEPTH are dropped
//   rd_address  read address; reads at or beyond DEPTH load zero
//   data_out    read data
module dual_port_ram_core #(
    parameter int unsigned ADDR_SIZE = 4,
    parameter int unsigned DATA_SIZE = 8,
    parameter int unsigned DEPTH     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cs,
    input  logic                 we,
    input  logic                 re,
    input  logic                 oe,
    input  logic [DATA_SIZE-1:0] data_in,
    output logic [DATA_SIZE-1:0] data_out,
    input  logic [ADDR_SIZE-1:0] wr_address,
    input  logic [ADDR_SIZE-1:0] rd_address
);

    // Word index width; DEPTH <= 2**ADDR_SIZE guarantees IdxW <= ADDR_SIZE.
    localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so DEPTH == 2**ADDR_SIZE is representable in the range compare.
    localparam logic [ADDR_SIZE:0] DepthW = (ADDR_SIZE + 1)'(DEPTH);

    logic [DATA_SIZE-1:0] mem_q [DEPTH];
    logic [DATA_SIZE-1:0] rd_q, rd_d;

    logic            wr_in_range, rd_in_range;
    logic            wr_en, rd_en;
    logic [IdxW-1:0] wr_idx, rd_idx;

    always_comb begin
        wr_in_range = ({1'b0, wr_address} < DepthW);
        rd_in_range = ({1'b0, rd_address} < DepthW);
        wr_en       = cs && we && wr_in_range;
        rd_en       = cs && re;
        wr_idx      = wr_address[IdxW-1:0];
        rd_idx      = rd_address[IdxW-1:0];
    end

    // Read register next state: write-first on a same-address collision, zero when the
    // read address is out of range, otherwise hold.
    always_comb begin
        rd_d = rd_q;
        if (rd_en) begin
            if (!rd_in_range) begin
                rd_d = '0;
            end else if (wr_en && (wr_address == rd_address)) begin
                rd_d = data_in;
            end else begin
                rd_d = mem_q[rd_idx];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_idx] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q <= '0;
        end else begin
            rd_q <= rd_d;
        end
    end

    // Output gating only; never tri-stated.
    assign data_out = oe ? rd_q : '0;

endmodule

// File: tb/tb_dual_port_ram_core.sv
// Testbench for dual_port_ram_core. Two instances share all stimulus: u_dut_a with
// DEPTH=16 and u_dut_b with DEPTH=12 (for the out-of-range cases).
module tb_dual_port_ram_core;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cs, we, re, oe;
    logic [7:0] data_in;
    logic [3:0] wr_address, rd_address;
    logic [7:0] data_a, data_b;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] exp_q_a [$];
    logic [7:0] exp_q_b [$];

    typedef struct {
        logic       cs, we, re, oe;
        logic [3:0] wa, ra;
        logic [7:0] din;
        logic [7:0] exp_a, exp_b;
    } vec_t;

    vec_t tbl [18];

    always #5 clk = ~clk;

    dual_port_ram_core #(.ADDR_SIZE(4), .DATA_SIZE(8), .DEPTH(16)) u_dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .cs         (cs),
        .we         (we),
        .re         (re),
        .oe         (oe),
        .data_in    (data_in),
        .data_out   (data_a),
        .wr_address (wr_address),
        .rd_address (rd_address)
    );

    dual_port_ram_core #(.ADDR_SIZE(4), .DATA_SIZE(8), .DEPTH(12)) u_dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .cs         (cs),
        .we         (we),
        .re         (re),
        .oe         (oe),
        .data_in    (data_in),
        .data_out   (data_b),
        .wr_address (wr_address),
        .rd_address (rd_address)
    );

    task automatic check(input string nm, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue expected outputs, compare after the edge.
    task automatic step(input logic c, input logic w, input logic r, input logic o,
                        input logic [3:0] wa, input logic [3:0] ra, input logic [7:0] d,
                        input logic [7:0] ea, input logic [7:0] eb, input string nm);
        @(negedge clk);
        cs = c; we = w; re = r; oe = o;
        wr_address = wa; rd_address = ra; data_in = d;
        exp_q_a.push_back(ea);
        exp_q_b.push_back(eb);
        @(posedge clk);
        #1;
        check({nm, "/a"}, data_a, exp_q_a.pop_front());
        check({nm, "/b"}, data_b, exp_q_b.pop_front());
    endtask

    function automatic logic [3:0] seq(input int k);
        return (k < 15) ? 4'(k + 1) : 4'd0;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        cs = 1'b0; we = 1'b0; re = 1'b0; oe = 1'b1;
        data_in = '0; wr_address = '0; rd_address = '0;

        // Fill/readback table: reads trail writes by two cycles.
        for (int c = 0; c < 18; c++) begin
            tbl[c].cs    = 1'b1;
            tbl[c].oe    = 1'b1;
            tbl[c].we    = (c < 16);
            tbl[c].wa    = (c < 16) ? seq(c) : 4'd0;
            tbl[c].din   = (c < 16) ? {4'd0, seq(c)} : 8'd0;
            tbl[c].re    = (c >= 2);
            tbl[c].ra    = (c >= 2) ? seq(c - 2) : 4'd0;
            tbl[c].exp_a = (c >= 2) ? {4'd0, seq(c - 2)} : 8'd0;
            tbl[c].exp_b = (c >= 2 && seq(c - 2) < 4'd12) ? {4'd0, seq(c - 2)} : 8'd0;
        end

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_out/a", data_a, 8'h00);
        check("reset_out/b", data_b, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // 1. Reset then read
        step(1, 0, 1, 1, 4'd0, 4'd5, 8'h00, 8'h00, 8'h00, "rst_read5");

        // 2. Fill and readback
        for (int c = 0; c < 18; c++) begin
            step(tbl[c].cs, tbl[c].we, tbl[c].re, tbl[c].oe, tbl[c].wa, tbl[c].ra,
                 tbl[c].din, tbl[c].exp_a, tbl[c].exp_b, $sformatf("fill_%0d", c));
        end

        // 3. Collision, write-first
        step(1, 1, 1, 1, 4'd3, 4'd3, 8'hA5, 8'hA5, 8'hA5, "collide3");
        step(1, 0, 1, 1, 4'd0, 4'd1, 8'h00, 8'h01, 8'h01, "read1");
        step(1, 0, 1, 1, 4'd0, 4'd3, 8'h00, 8'hA5, 8'hA5, "reread3");

        // 4. Gating: cs=0 blocks write and read; oe gates combinationally
        step(0, 1, 1, 1, 4'd4, 4'd1, 8'h55, 8'hA5, 8'hA5, "cs0_hold");
        step(1, 0, 1, 1, 4'd0, 4'd4, 8'h00, 8'h04, 8'h04, "cs0_mem4");
        step(1, 0, 0, 1, 4'd2, 4'd0, 8'hxx, 8'h04, 8'h04, "x_data_we0");
        step(1, 0, 1, 0, 4'd0, 4'd2, 8'h00, 8'h00, 8'h00, "oe0_read2");
        oe = 1'b1;
        #1;
        check("oe_rise/a", data_a, 8'h02);
        check("oe_rise/b", data_b, 8'h02);
        step(1, 0, 1, 1, 4'd0, 4'd2, 8'h00, 8'h02, 8'h02, "read2_after_x");

        // 5. Async reset mid-operation
        step(1, 1, 0, 1, 4'd7, 4'd0, 8'h77, 8'h02, 8'h02, "wr7");
        step(1, 0, 1, 1, 4'd0, 4'd7, 8'h00, 8'h77, 8'h77, "read7");
        @(negedge clk);
        cs = 1'b0; we = 1'b0; re = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("async_rst/a", data_a, 8'h00);
        check("async_rst/b", data_b, 8'h00);
        #1 rst_n = 1'b1;
        step(1, 0, 1, 1, 4'd0, 4'd7, 8'h00, 8'h00, 8'h00, "read7_post_rst");
        step(1, 0, 1, 1, 4'd0, 4'd3, 8'h00, 8'h00, 8'h00, "read3_post_rst");

        // 6. Out-of-range on the DEPTH=12 instance
        for (int k = 0; k < 12; k++) begin
            step(1, 1, 0, 1, 4'(k), 4'd0, 8'(k + 16), 8'h00, 8'h00, $sformatf("pre_wr_%0d", k));
        end
        for (int k = 12; k < 16; k++) begin
            step(1, 1, 0, 1, 4'(k), 4'd0, 8'hFF, 8'h00, 8'h00, $sformatf("oor_wr_%0d", k));
        end
        step(1, 1, 1, 1, 4'd13, 4'd13, 8'hFF, 8'hFF, 8'h00, "oor_rw13");
        step(1, 0, 1, 1, 4'd0, 4'd14, 8'h00, 8'hFF, 8'h00, "oor_rd14");
        for (int k = 0; k < 12; k++) begin
            step(1, 0, 1, 1, 4'd0, 4'(k), 8'h00, 8'(k + 16), 8'(k + 16),
                 $sformatf("post_rd_%0d", k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
